pcap_framer: RTL
================

# pcap_framer

Front-end stage feeding `udp_parser`. Reads a raw libpcap byte stream from an input FIFO and validates and strips the 24-byte global header and each 16-byte per-packet record header. Writes only the captured Ethernet frame bytes into the downstream FIFO, tagged with start-of-frame/end-of-frame. `udp_parser` consumes that FIFO through its `in_sof`/`in_eof`/`din`/`empty` interface.

## Interface
- `PCAP_HEADER_BYTES`, 24, global header length
- `PCAP_DATA_HEADER_BYTES`, 16, per-packet record header length
- `DATA_WIDTH`, 8, byte lane width
- `MAX_PKT_BYTES`, 1518, largest accepted incl_len
- `PKT_COUNT_WIDTH`, 16, width of forwarded-packet counter
- `clock`  in  1  single clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- `din`  in  DATA_WIDTH  head byte of input FIFO (first-word-fall-through)
- `in_empty`  in  1  input FIFO empty
- `in_rd_en`  out  1  pop input FIFO this cycle
- `out_full`  in  1  output FIFO full
- `out_wr_en`  out  1  push output FIFO this cycle
- `out_dout`  out  DATA_WIDTH  frame byte to output FIFO
- `out_sof`  out  1  accompanies first frame byte
- `out_eof`  out  1  accompanies last frame byte
- `error`  out  1  sticky: bad magic or oversize/zero-illegal record
- `pkt_count`  out  PKT_COUNT_WIDTH  frames fully forwarded (eof written)

## Operation
- States: `S_GLOBAL_HDR`, `S_PKT_HDR`, `S_PKT_DATA`, `S_ERROR`. Reset state is `S_GLOBAL_HDR`, with `byte_cnt`=0, `incl_len`=0, and `big_endian`=0.
- Header states: `in_rd_en = !in_empty`. A byte is consumed when `in_rd_en` is 1, and `byte_cnt` then increments.
- `S_GLOBAL_HDR`, bytes 0..3 (magic):
  - Sequence D4 C3 B2 A1 selects little-endian.
  - Sequence A1 B2 C3 D4 selects big-endian.
  - Any byte that matches neither sequence at its position sends the block to `S_ERROR` on that cycle.
  - Bytes 4..23 are discarded.
  - After byte 23: `byte_cnt` goes to 0 and the state goes to `S_PKT_HDR`.
- `S_PKT_HDR`: bytes 8..11 form `incl_len`.
  - Little-endian: `incl_len <= {din, incl_len[31:8]}`.
  - Big-endian: `incl_len <= {incl_len[23:0], din}`.
  - All other bytes are discarded.
  - Decision is made on byte 15, with `byte_cnt` cleared:
    - `incl_len == 0`: stay in `S_PKT_HDR`; the record is skipped silently.
    - `incl_len > MAX_PKT_BYTES`: go to `S_ERROR`.
    - Otherwise: go to `S_PKT_DATA`.
- `S_PKT_DATA`:
  - `in_rd_en = out_wr_en = !in_empty && !out_full`.
  - `out_dout = din` (pass-through).
  - `out_sof = out_wr_en && byte_cnt==0`.
  - `out_eof = out_wr_en && byte_cnt==incl_len-1`.
  - On the eof write: `pkt_count` increments, `byte_cnt` goes to 0, and the state returns to `S_PKT_HDR`.
- `S_ERROR`:
  - `error`=1.
  - `in_rd_en`=0 and `out_wr_en`=0 forever.
  - Only `reset` exits this state.
- Width rules:
  - `byte_cnt` is 16 bits. Comparison against `incl_len` is done at 32 bits, with `byte_cnt` zero-extended.
  - `pkt_count` wraps modulo 2^PKT_COUNT_WIDTH.

## Timing
- Zero-cycle latency: `out_dout`, `out_wr_en`, `out_sof` and `out_eof` are combinational from `din`, state and the counters.
- Throughput is 1 byte per cycle when unstalled. Per frame, overhead is 16 header cycles plus `incl_len` data cycles.
- All outputs read 0 while `reset`=0, and `pkt_count`=0.
- Stall behaviour:
  - `in_empty` or `out_full` in `S_PKT_DATA` freezes all state.
  - `out_sof`/`out_eof` are reasserted with the byte when it finally writes.
  - A stall never loses or duplicates a byte.
- `incl_len`=1: `out_sof` and `out_eof` are both 1 on the single write.
- `out_full` is ignored in header states. Header bytes are never written.
- Reset asserted mid-frame:
  - State returns to `S_GLOBAL_HDR` immediately, and the partial frame is abandoned with no eof.
  - The input stream is expected to restart at a new global header.
- End of input mid-record: the block waits indefinitely in its current state. There is no timeout.

## Structure
- `pcap_pkg`:
  - `pcap_state_t` enum.
  - `PCAP_MAGIC_LE` = 32'hA1B2C3D4 and its byte-order constants.
  - Header length localparams.
  - `INCL_LEN_OFFSET` = 8.
- Single module: a two-process FSM (registered state plus `*_c` next-state comb block). No sub-module is needed.
- FIFOs are instantiated by the parent, alongside `udp_parser`.

## Test plan
- LE global header plus one record with `incl_len`=60, no stalls:
  - 60 writes; `out_sof` on byte 0, `out_eof` on byte 59.
  - `pkt_count`=1 and `error`=0.
  - Output bytes equal input bytes 40..99.
- BE magic A1 B2 C3 D4 with incl_len bytes 00 00 00 2A: exactly 42 bytes forwarded, with sof/eof correct.
- Three records with lengths 64, 0 and 1:
  - 65 writes in total.
  - The 1-byte frame has sof and eof in the same cycle.
  - `pkt_count`=2.
- Random `in_empty`/`out_full` toggling over a 100-byte frame: output byte sequence matches input exactly and sof/eof fire once each.
- Bad magic D4 C3 B2 A0: `error` goes to 1 after byte 3; `in_rd_en` stays 0 for the next 50 cycles.
- `incl_len`=1519: `error` goes to 1 with no writes. Then assert `reset` mid-frame of a new valid stream: outputs go to 0 immediately, and after release a fresh file parses correctly.

Source files
------------

// File: rtl/pcap_pkg.sv
// Shared types and constants for the libpcap front-end framer.
package pcap_pkg;

    localparam int unsigned DATA_WIDTH             = 8;
    localparam int unsigned PCAP_HEADER_BYTES      = 24;
    localparam int unsigned PCAP_DATA_HEADER_BYTES = 16;
    localparam int unsigned MAX_PKT_BYTES          = 1518;
    localparam int unsigned PKT_COUNT_WIDTH        = 16;
    localparam int unsigned BYTE_CNT_WIDTH         = 16;
    localparam int unsigned INCL_LEN_WIDTH         = 32;
    localparam int unsigned INCL_LEN_OFFSET        = 8;
    localparam int unsigned INCL_LEN_BYTES         = 4;
    localparam int unsigned MAGIC_BYTES            = 4;

    // Magic word as written by a little-endian host (file bytes D4 C3 B2 A1)
    // and by a big-endian host (file bytes A1 B2 C3 D4); byte k of the file is bits [8k+7:8k].
    localparam logic [31:0] PCAP_MAGIC_LE = 32'hA1B2C3D4;
    localparam logic [31:0] PCAP_MAGIC_BE = 32'hD4C3B2A1;

    typedef enum logic [1:0] {
        S_GLOBAL_HDR,
        S_PKT_HDR,
        S_PKT_DATA,
        S_ERROR
    } pcap_state_t;

    // Expected magic byte at file position idx for the selected byte order.
    function automatic logic [7:0] magic_byte(input logic big_endian, input logic [1:0] idx);
        logic [31:0] w_order;
        w_order = big_endian ? PCAP_MAGIC_BE : PCAP_MAGIC_LE;
        return 8'(w_order >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/pcap_framer_if.sv
// FIFO-side signal bundle of pcap_framer: input FIFO head, output FIFO push, status.
interface pcap_framer_if;
    import pcap_pkg::*;

    logic [DATA_WIDTH-1:0]      din;
    logic                       in_empty;
    logic                       in_rd_en;
    logic                       out_full;
    logic                       out_wr_en;
    logic [DATA_WIDTH-1:0]      out_dout;
    logic                       out_sof;
    logic                       out_eof;
    logic                       error;
    logic [PKT_COUNT_WIDTH-1:0] pkt_count;

    modport master (
        input  din, in_empty, out_full,
        output in_rd_en, out_wr_en, out_dout, out_sof, out_eof, error, pkt_count
    );

    modport slave (
        output din, in_empty, out_full,
        input  in_rd_en, out_wr_en, out_dout, out_sof, out_eof, error, pkt_count
    );
endinterface

// File: rtl/pcap_framer.sv
// Strips the libpcap global and per-record headers from a byte stream and forwards
// only captured frame bytes, tagged with sof/eof, toward udp_parser's input FIFO.
module pcap_framer
    import pcap_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    pcap_framer_if.master bus
);

    pcap_state_t                r_state,      w_state_c;
    logic [BYTE_CNT_WIDTH-1:0]  r_byte_cnt,   w_byte_cnt_c;
    logic [INCL_LEN_WIDTH-1:0]  r_incl_len,   w_incl_len_c;
    logic                       r_big_endian, w_big_endian_c;
    logic [PKT_COUNT_WIDTH-1:0] r_pkt_count,  w_pkt_count_c;

    logic w_rd_en_c;
    logic w_wr_en_c;
    logic w_sof_c;
    logic w_eof_c;
    logic w_last_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_GLOBAL_HDR;
            r_byte_cnt   <= '0;
            r_incl_len   <= '0;
            r_big_endian <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_c;
            r_byte_cnt   <= w_byte_cnt_c;
            r_incl_len   <= w_incl_len_c;
            r_big_endian <= w_big_endian_c;
            r_pkt_count  <= w_pkt_count_c;
        end
    end

    // Byte counter zero-extended to 32 bits so the last-byte test never truncates incl_len.
    assign w_last_c = (INCL_LEN_WIDTH'(r_byte_cnt) == (r_incl_len - INCL_LEN_WIDTH'(1)));

    always_comb begin
        w_state_c      = r_state;
        w_byte_cnt_c   = r_byte_cnt;
        w_incl_len_c   = r_incl_len;
        w_big_endian_c = r_big_endian;
        w_pkt_count_c  = r_pkt_count;
        w_rd_en_c      = 1'b0;
        w_wr_en_c      = 1'b0;
        w_sof_c        = 1'b0;
        w_eof_c        = 1'b0;

        unique case (r_state)
            S_GLOBAL_HDR: begin
                w_rd_en_c = !bus.in_empty;
                if (w_rd_en_c) begin
                    w_byte_cnt_c = r_byte_cnt + BYTE_CNT_WIDTH'(1);
                    // Byte 0 picks the byte order; bytes 1..3 must continue that same sequence.
                    if (r_byte_cnt == '0) begin
                        if (bus.din == magic_byte(1'b0, 2'd0)) begin
                            w_big_endian_c = 1'b0;
                        end else if (bus.din == magic_byte(1'b1, 2'd0)) begin
                            w_big_endian_c = 1'b1;
                        end else begin
                            w_state_c = S_ERROR;
                        end
                    end else if (r_byte_cnt < BYTE_CNT_WIDTH'(MAGIC_BYTES)) begin
                        if (bus.din != magic_byte(r_big_endian, 2'(r_byte_cnt))) begin
                            w_state_c = S_ERROR;
                        end
                    end else if (r_byte_cnt == BYTE_CNT_WIDTH'(PCAP_HEADER_BYTES - 1)) begin
                        w_byte_cnt_c = '0;
                        w_state_c    = S_PKT_HDR;
                    end
                end
            end

            S_PKT_HDR: begin
                w_rd_en_c = !bus.in_empty;
                if (w_rd_en_c) begin
                    w_byte_cnt_c = r_byte_cnt + BYTE_CNT_WIDTH'(1);
                    if ((r_byte_cnt >= BYTE_CNT_WIDTH'(INCL_LEN_OFFSET)) &&
                        (r_byte_cnt <  BYTE_CNT_WIDTH'(INCL_LEN_OFFSET + INCL_LEN_BYTES))) begin
                        if (r_big_endian) begin
                            w_incl_len_c = {r_incl_len[INCL_LEN_WIDTH-DATA_WIDTH-1:0], bus.din};
                        end else begin
                            w_incl_len_c = {bus.din, r_incl_len[INCL_LEN_WIDTH-1:DATA_WIDTH]};
                        end
                    end
                    // incl_len is complete after byte 11, so the verdict on byte 15 uses the register.
                    if (r_byte_cnt == BYTE_CNT_WIDTH'(PCAP_DATA_HEADER_BYTES - 1)) begin
                        w_byte_cnt_c = '0;
                        if (r_incl_len == '0) begin
                            w_state_c = S_PKT_HDR;
                        end else if (r_incl_len > INCL_LEN_WIDTH'(MAX_PKT_BYTES)) begin
                            w_state_c = S_ERROR;
                        end else begin
                            w_state_c = S_PKT_DATA;
                        end
                    end
                end
            end

            S_PKT_DATA: begin
                w_wr_en_c = !bus.in_empty && !bus.out_full;
                w_rd_en_c = w_wr_en_c;
                w_sof_c   = w_wr_en_c && (r_byte_cnt == '0);
                w_eof_c   = w_wr_en_c && w_last_c;
                if (w_wr_en_c) begin
                    if (w_last_c) begin
                        w_byte_cnt_c  = '0;
                        w_pkt_count_c = r_pkt_count + PKT_COUNT_WIDTH'(1);
                        w_state_c     = S_PKT_HDR;
                    end else begin
                        w_byte_cnt_c = r_byte_cnt + BYTE_CNT_WIDTH'(1);
                    end
                end
            end

            S_ERROR: begin
                w_state_c = S_ERROR;
            end

            default: begin
                w_state_c = S_ERROR;
            end
        endcase
    end

    // Everything reads zero while reset is held, even though the state is already idle.
    assign bus.in_rd_en  = reset & w_rd_en_c;
    assign bus.out_wr_en = reset & w_wr_en_c;
    assign bus.out_sof   = reset & w_sof_c;
    assign bus.out_eof   = reset & w_eof_c;
    assign bus.out_dout  = (reset && (r_state == S_PKT_DATA)) ? bus.din : '0;
    assign bus.error     = reset & (r_state == S_ERROR);
    assign bus.pkt_count = r_pkt_count;

endmodule
